// File: rtl/mult_eval_pkg.sv
// Shared types and constants for the exhaustive multiplier evaluation sweeper.
package mult_eval_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } eval_state_t;

    localparam int DEFAULT_WIDTH = 2;

    // Number of operand pairs covered by an exhaustive sweep of width w.
    function automatic int vec_count(input int w);
        return 1 << (2 * w);
    endfunction

endpackage

// File: rtl/mult_eval_cmp.sv
// Capture register and compare/accumulate stage: registers the candidate product
// alongside the golden product, then folds mismatches into the error statistics.
module mult_eval_cmp
    import mult_eval_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               drive,
    input  logic [WIDTH-1:0]   op_a,
    input  logic [WIDTH-1:0]   op_b,
    input  logic [2*WIDTH-1:0] mult_p,
    output logic [2*WIDTH:0]   error_count,
    output logic [2*WIDTH-1:0] err_bits,
    output logic               fail_seen,
    output logic [WIDTH-1:0]   first_fail_a,
    output logic [WIDTH-1:0]   first_fail_b
);

    localparam int PW = 2 * WIDTH;
    localparam int EW = 2 * WIDTH + 1;

    logic [PW-1:0]    cap_p;
    logic [PW-1:0]    cap_exp;
    logic [WIDTH-1:0] cap_a;
    logic [WIDTH-1:0] cap_b;
    logic             cap_vld;
    logic [PW-1:0]    golden;
    logic             mismatch;

    assign golden   = PW'(op_a) * PW'(op_b);
    assign mismatch = cap_vld && (cap_p != cap_exp);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_p   <= '0;
            cap_exp <= '0;
            cap_a   <= '0;
            cap_b   <= '0;
            cap_vld <= 1'b0;
        end else begin
            cap_vld <= drive;
            if (drive) begin
                cap_p   <= mult_p;
                cap_exp <= golden;
                cap_a   <= op_a;
                cap_b   <= op_b;
            end
        end
    end

    // Clear only happens in IDLE where cap_vld is already low, so it never drops a compare.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            error_count  <= '0;
            err_bits     <= '0;
            fail_seen    <= 1'b0;
            first_fail_a <= '0;
            first_fail_b <= '0;
        end else if (clear) begin
            error_count  <= '0;
            err_bits     <= '0;
            fail_seen    <= 1'b0;
            first_fail_a <= '0;
            first_fail_b <= '0;
        end else if (mismatch) begin
            error_count <= error_count + EW'(1);
            err_bits    <= err_bits | (cap_p ^ cap_exp);
            if (!fail_seen) begin
                fail_seen    <= 1'b1;
                first_fail_a <= cap_a;
                first_fail_b <= cap_b;
            end
        end
    end

endmodule

// File: rtl/mult_eval_sweeper.sv
// Exhaustive-sweep controller: walks every operand pair through a combinational
// candidate multiplier and reports mismatch statistics against a golden a*b.
module mult_eval_sweeper
    import mult_eval_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    output logic [WIDTH-1:0]   op_a,
    output logic [WIDTH-1:0]   op_b,
    input  logic [2*WIDTH-1:0] mult_p,
    output logic               busy,
    output logic               done,
    output logic               complete,
    output logic [2*WIDTH:0]   error_count,
    output logic [2*WIDTH-1:0] err_bits,
    output logic               fail_seen,
    output logic [WIDTH-1:0]   first_fail_a,
    output logic [WIDTH-1:0]   first_fail_b
);

    localparam int IW = 2 * WIDTH;
    localparam int N  = vec_count(WIDTH);
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    eval_state_t   state;
    eval_state_t   next_state;
    logic [IW-1:0] idx;
    logic [IW-1:0] next_idx;
    logic          accept;
    logic          drive;

    assign accept = (state == IDLE) && start;
    assign drive  = (state == SWEEP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= next_state;
            idx   <= next_idx;
        end
    end

    always_comb begin
        next_state = state;
        next_idx   = '0;
        case (state)
            IDLE: begin
                if (start) next_state = SWEEP;
            end
            SWEEP: begin
                if (abort) begin
                    next_state = DONE;
                end else if (idx == LAST_IDX) begin
                    next_state = FLUSH;
                end else begin
                    next_idx = idx + IW'(1);
                end
            end
            FLUSH:   next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // complete is only raised by a FLUSH that was not interrupted by abort.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            complete <= 1'b0;
        end else if (accept) begin
            complete <= 1'b0;
        end else if ((state == FLUSH) && !abort) begin
            complete <= 1'b1;
        end
    end

    assign op_a = drive ? idx[IW-1:WIDTH] : '0;
    assign op_b = drive ? idx[WIDTH-1:0]  : '0;
    assign busy = (state == SWEEP) || (state == FLUSH);
    assign done = (state == DONE);

    mult_eval_cmp #(
        .WIDTH(WIDTH)
    ) u_cmp (
        .clk          (clk),
        .rst          (rst),
        .clear        (accept),
        .drive        (drive),
        .op_a         (op_a),
        .op_b         (op_b),
        .mult_p       (mult_p),
        .error_count  (error_count),
        .err_bits     (err_bits),
        .fail_seen    (fail_seen),
        .first_fail_a (first_fail_a),
        .first_fail_b (first_fail_b)
    );

endmodule

// File: tb/tb_mult_eval_sweeper.sv
// Bench for mult_eval_sweeper: behavioural candidate plus a sweep-level reference model.
module tb_mult_eval_sweeper;

    localparam int W = 2;
    localparam int N = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic [W-1:0] op_a, op_b;
    logic [2*W-1:0] mult_p;
    logic         busy, done, complete, fail_seen;
    logic [2*W:0] error_count;
    logic [2*W-1:0] err_bits;
    logic [W-1:0] first_fail_a, first_fail_b;

    int checks = 0;
    int passes = 0;
    int mode = 0;
    logic [3:0] mask_tbl [16];

    int exp_ec, exp_bits, exp_fa, exp_fb;
    bit exp_fs;

    mult_eval_sweeper #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .op_a(op_a), .op_b(op_b), .mult_p(mult_p),
        .busy(busy), .done(done), .complete(complete),
        .error_count(error_count), .err_bits(err_bits), .fail_seen(fail_seen),
        .first_fail_a(first_fail_a), .first_fail_b(first_fail_b)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] cand(input int a, input int b);
        logic [3:0] prod;
        prod = 4'(a * b);
        case (mode)
            0:       return prod;
            1:       return 4'd0;
            2:       return prod & 4'b0111;
            default: return prod ^ mask_tbl[(a << 2) | b];
        endcase
    endfunction

    always_comb mult_p = cand(int'(op_a), int'(op_b));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s actual=%0h required=%0h", name, act, req);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected statistics for vectors 0..last, straight from the sweep definition.
    task automatic model(input int last);
        int a, b, g, p;
        exp_ec = 0; exp_bits = 0; exp_fa = 0; exp_fb = 0; exp_fs = 0;
        for (int i = 0; i <= last; i++) begin
            a = i / 4;
            b = i % 4;
            g = a * b;
            p = int'(cand(a, b));
            if (p != g) begin
                exp_ec++;
                exp_bits |= (p ^ g);
                if (!exp_fs) begin
                    exp_fs = 1; exp_fa = a; exp_fb = b;
                end
            end
        end
    endtask

    task automatic chk_results(input string tag);
        chk({tag, "_error_count"}, 32'(error_count), 32'(exp_ec));
        chk({tag, "_err_bits"}, 32'(err_bits), 32'(exp_bits));
        chk({tag, "_fail_seen"}, 32'(fail_seen), 32'(exp_fs));
        chk({tag, "_first_fail_a"}, 32'(first_fail_a), 32'(exp_fa));
        chk({tag, "_first_fail_b"}, 32'(first_fail_b), 32'(exp_fb));
    endtask

    // Runs one sweep from IDLE, checking every cycle; returns in the IDLE cycle after done.
    task automatic run_sweep(input int abort_at, input bit abort_flush, input bit hold, input bit ab_start);
        int  last;
        bit  aborted;
        start = 1'b1;
        abort = ab_start;
        step();
        if (!hold) start = 1'b0;
        abort = 1'b0;
        last = N - 1;
        aborted = 0;
        for (int i = 0; i < N; i++) begin
            chk("sweep_busy", 32'(busy), 1);
            chk("sweep_done", 32'(done), 0);
            chk("sweep_op_a", 32'(op_a), 32'(i / 4));
            chk("sweep_op_b", 32'(op_b), 32'(i % 4));
            if (i == abort_at) begin
                abort = 1'b1;
                last = i;
                aborted = 1;
            end
            step();
            abort = 1'b0;
            if (aborted) break;
        end
        if (!aborted) begin
            chk("flush_busy", 32'(busy), 1);
            chk("flush_ops", 32'({op_a, op_b}), 0);
            if (abort_flush) begin
                abort = 1'b1;
                aborted = 1;
            end
            step();
            abort = 1'b0;
        end
        chk("done_pulse", 32'(done), 1);
        chk("done_busy", 32'(busy), 0);
        chk("done_complete", 32'(complete), 32'(!aborted));
        chk("done_ops", 32'({op_a, op_b}), 0);
        step();
        chk("idle_done", 32'(done), 0);
        chk("idle_complete", 32'(complete), 32'(!aborted));
        model(last);
        chk_results("sweep");
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mask_tbl[i] = 4'd0;
        step();
        step();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_stats", 32'({complete, error_count, err_bits, fail_seen, first_fail_a, first_fail_b}), 0);
        rst = 1'b0;
        step();

        // Exact candidate.
        mode = 0;
        run_sweep(-1, 0, 0, 0);
        chk("lit_exact_ec", 32'(error_count), 0);
        chk("lit_exact_bits", 32'(err_bits), 0);
        chk("lit_exact_fs", 32'(fail_seen), 0);

        // Stuck-at-zero candidate.
        mode = 1;
        run_sweep(-1, 0, 0, 0);
        chk("lit_zero_ec", 32'(error_count), 9);
        chk("lit_zero_bits", 32'(err_bits), 32'hF);
        chk("lit_zero_first", 32'({first_fail_a, first_fail_b}), 32'b0101);

        // Top product bit forced low.
        mode = 2;
        run_sweep(-1, 0, 0, 0);
        chk("lit_p3_ec", 32'(error_count), 1);
        chk("lit_p3_bits", 32'(err_bits), 32'h8);
        chk("lit_p3_first", 32'({first_fail_a, first_fail_b}), 32'b1111);

        // Stuck-at-zero, aborted while vector (1,1) is driven.
        mode = 1;
        run_sweep(5, 0, 0, 0);
        chk("lit_abort_ec", 32'(error_count), 1);
        chk("lit_abort_complete", 32'(complete), 0);
        chk("lit_abort_first", 32'({first_fail_a, first_fail_b}), 32'b0101);

        // Abort during FLUSH still counts every vector.
        run_sweep(-1, 1, 0, 0);

        // Reset mid-sweep.
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 7; i++) step();
        chk("pre_rst_busy", 32'(busy), 1);
        rst = 1'b1;
        #1;
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_done", 32'(done), 0);
        chk("midrst_ops", 32'({op_a, op_b}), 0);
        chk("midrst_stats", 32'({complete, error_count, err_bits, fail_seen, first_fail_a, first_fail_b}), 0);
        step();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("post_rst_done", 32'(done), 0);
            chk("post_rst_busy", 32'(busy), 0);
        end
        run_sweep(-1, 0, 0, 0);

        // Start held high: next sweep accepted in the IDLE cycle after DONE.
        mode = 1;
        run_sweep(-1, 0, 1, 0);
        step();
        start = 1'b0;
        chk("hold_restart_busy", 32'(busy), 1);
        chk("hold_cleared", 32'({complete, error_count, err_bits, fail_seen, first_fail_a, first_fail_b}), 0);
        for (int i = 0; i < N + 1; i++) step();
        chk("hold_second_done", 32'(done), 1);
        chk("hold_second_ec", 32'(error_count), 9);
        step();

        // Randomised candidates and abort points; some sweeps start with abort also high.
        mode = 3;
        for (int r = 0; r < 8; r++) begin
            int ab;
            for (int i = 0; i < 16; i++) mask_tbl[i] = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'd0;
            ab = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, N - 1)) : -1;
            run_sweep(ab, bit'($urandom_range(0, 1)), 0, bit'($urandom_range(0, 1)));
            for (int i = 0; i < int'($urandom_range(0, 2)); i++) step();
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
